// File: rtl/mini_mips_pkg.sv
// Shared definitions for the HI/LO multiply unit: op encoding, FSM states, default width.
package mini_mips_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT_OP_MUL   = 2'b00,
    MULT_OP_MADD  = 2'b01,
    MULT_OP_MADDU = 2'b10,
    MULT_OP_MULU  = 2'b11
  } mult_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } mult_state_e;

  function automatic logic is_signed_op(input mult_op_e op);
    return (op == MULT_OP_MUL) || (op == MULT_OP_MADD);
  endfunction

  function automatic logic is_accum_op(input mult_op_e op);
    return (op == MULT_OP_MADD) || (op == MULT_OP_MADDU);
  endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add magnitude multiplier; o_result carries the sign-corrected product.
module mult_shift_add
  import mini_mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_sign;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  // Unsigned negation keeps -2^(W-1) as magnitude 2^(W-1) without overflow
  assign w_mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
    end else if (i_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_sign   <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (i_step) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign o_last   = (r_cnt == CW'(WIDTH - 1));
  assign o_result = r_sign ? -r_prod : r_prod;

endmodule

// File: rtl/hilo_mult_sequencer.sv
// HI/LO register file with IDLE/RUN/FINISH sequencing of a multi-cycle multiply/accumulate.
module hilo_mult_sequencer
  import mini_mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  mult_op_e         i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_hi_wr_en,
  input  logic             i_lo_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  mult_state_e        r_state;
  mult_op_e           r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_result;
  logic [2*WIDTH-1:0] w_acc_sum;

  assign w_load    = (r_state == ST_IDLE) && i_start;
  assign w_step    = (r_state == ST_RUN);
  assign w_acc_sum = {r_hi, r_lo} + w_result;

  mult_shift_add #(.WIDTH(WIDTH)) u_dp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_signed (is_signed_op(i_op)),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (w_result),
    .o_last   (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_op    <= MULT_OP_MUL;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Direct writes and an accepted start may share an edge
          if (i_hi_wr_en) r_hi <= i_wr_data;
          if (i_lo_wr_en) r_lo <= i_wr_data;
          if (i_start) begin
            r_op    <= i_op;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: if (w_last) r_state <= ST_FINISH;
        ST_FINISH: begin
          if (is_accum_op(r_op)) {r_hi, r_lo} <= w_acc_sum;
          else                   {r_hi, r_lo} <= w_result;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_stall = o_busy;
  assign o_done  = r_done;

endmodule
